// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, presents it to the
// instruction memory and captures the returned word into the IF/ID register.
// Handles decode stalls, branch redirects with a one-bubble flush, and
// sticky faults for misaligned or out-of-range fetch addresses.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_PC,
    output logic        IF_ID_valid,
    output logic        fault,
    output logic [31:0] faultPC,
    output logic [31:0] fetchCount
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    typedef enum logic {
        RUN,
        FAULT
    } fetchState_t;

    fetchState_t stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] ifIdInstrQ, ifIdInstrD;
    logic [31:0] ifIdPcQ, ifIdPcD;
    logic        ifIdValidQ, ifIdValidD;
    logic        faultQ, faultD;
    logic [31:0] faultPcQ, faultPcD;
    logic [31:0] fetchCountQ, fetchCountD;

    logic targetBad;
    logic pcBad;

    assign targetBad = (branchTarget[1:0] != 2'b00) || (branchTarget >= PC_LIMIT);
    assign pcBad     = (pcQ >= PC_LIMIT);

    // Next-state logic: branch wins over fault detection, which wins over stall,
    // which wins over a normal advance; the FAULT state freezes everything.
    always_comb begin
        stateD      = stateQ;
        pcD         = pcQ;
        ifIdInstrD  = ifIdInstrQ;
        ifIdPcD     = ifIdPcQ;
        ifIdValidD  = ifIdValidQ;
        faultD      = faultQ;
        faultPcD    = faultPcQ;
        fetchCountD = fetchCountQ;

        case (stateQ)
            RUN: begin
                if (branchTaken) begin
                    if (targetBad) begin
                        stateD     = FAULT;
                        faultD     = 1'b1;
                        faultPcD   = branchTarget;
                        ifIdValidD = 1'b0;
                    end else begin
                        pcD        = branchTarget;
                        ifIdValidD = 1'b0;
                    end
                end else if (!stall) begin
                    if (pcBad) begin
                        stateD     = FAULT;
                        faultD     = 1'b1;
                        faultPcD   = pcQ;
                        ifIdValidD = 1'b0;
                    end else begin
                        ifIdInstrD  = instruction;
                        ifIdPcD     = pcQ;
                        ifIdValidD  = 1'b1;
                        pcD         = pcQ + 32'd4;
                        fetchCountD = fetchCountQ + 32'd1;
                    end
                end
            end
            FAULT: begin
                stateD = FAULT;
            end
            default: begin
                stateD = RUN;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateQ      <= RUN;
            pcQ         <= RESET_PC;
            ifIdInstrQ  <= 32'd0;
            ifIdPcQ     <= 32'd0;
            ifIdValidQ  <= 1'b0;
            faultQ      <= 1'b0;
            faultPcQ    <= 32'd0;
            fetchCountQ <= 32'd0;
        end else begin
            stateQ      <= stateD;
            pcQ         <= pcD;
            ifIdInstrQ  <= ifIdInstrD;
            ifIdPcQ     <= ifIdPcD;
            ifIdValidQ  <= ifIdValidD;
            faultQ      <= faultD;
            faultPcQ    <= faultPcD;
            fetchCountQ <= fetchCountD;
        end
    end

    assign PC                = pcQ;
    assign IF_ID_instruction = ifIdInstrQ;
    assign IF_ID_PC          = ifIdPcQ;
    assign IF_ID_valid       = ifIdValidQ;
    assign fault             = faultQ;
    assign faultPC           = faultPcQ;
    assign fetchCount        = fetchCountQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_PC;
    logic        IF_ID_valid;
    logic        fault;
    logic [31:0] faultPC;
    logic [31:0] fetchCount;

    logic [31:0] imem [32];

    int total;
    int bad;

    // Behavioural model of the architectural state.
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mIfPc;
    logic        mValid;
    logic        mFault;
    logic [31:0] mFaultPc;
    logic [31:0] mCount;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .PC                (PC),
        .instruction       (instruction),
        .stall             (stall),
        .branchTaken       (branchTaken),
        .branchTarget      (branchTarget),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_valid       (IF_ID_valid),
        .fault             (fault),
        .faultPC           (faultPC),
        .fetchCount        (fetchCount)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Combinational instruction memory indexed by PC/4.
    assign instruction = imem[PC[6:2]];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("PC",         PC,                mPc);
        checkOutput("IF_ID_instr", IF_ID_instruction, mInstr);
        checkOutput("IF_ID_PC",   IF_ID_PC,          mIfPc);
        checkOutput("IF_ID_valid", 32'(IF_ID_valid), 32'(mValid));
        checkOutput("fault",      32'(fault),        32'(mFault));
        checkOutput("faultPC",    faultPC,           mFaultPc);
        checkOutput("fetchCount", fetchCount,        mCount);
    endtask

    // Advance the model by one clock edge using the rules of the stage.
    task automatic modelEdge(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
        if (!rst) begin
            mPc = 0; mInstr = 0; mIfPc = 0; mValid = 0;
            mFault = 0; mFaultPc = 0; mCount = 0;
        end else if (!mFault) begin
            if (br) begin
                if (tgt % 4 != 0 || tgt >= 128) begin
                    mFault = 1; mFaultPc = tgt; mValid = 0;
                end else begin
                    mPc = tgt; mValid = 0;
                end
            end else if (!stl) begin
                if (mPc >= 128) begin
                    mFault = 1; mFaultPc = mPc; mValid = 0;
                end else begin
                    mInstr = imem[mPc / 4];
                    mIfPc  = mPc;
                    mValid = 1;
                    mPc    = mPc + 4;
                    mCount = mCount + 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare everything after the edge.
    task automatic applyStimulus(input logic rst, input logic stl, input logic br, input logic [31:0] tgt);
        @(negedge clock);
        reset        = rst;
        stall        = stl;
        branchTaken  = br;
        branchTarget = tgt;
        @(posedge clock);
        modelEdge(rst, stl, br, tgt);
        #1;
        checkAll();
    endtask

    initial begin
        logic [31:0] t;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) imem[i] = $urandom;
        reset = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'd0;
        mPc = 32'hFFFF_FFFF; mInstr = 0; mIfPc = 0; mValid = 0;
        mFault = 0; mFaultPc = 0; mCount = 0;

        // Reset and four sequential fetches.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h44);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("run4_count", fetchCount, 32'd4);
        checkOutput("run4_ifpc", IF_ID_PC, 32'h0C);

        // Stall at PC=8 for three cycles, then release.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
        checkOutput("stall_pc", PC, 32'h08);
        checkOutput("stall_ifpc", IF_ID_PC, 32'h04);
        checkOutput("stall_count", fetchCount, 32'd2);
        applyStimulus(1, 0, 0, 0);
        checkOutput("release_ifpc", IF_ID_PC, 32'h08);
        checkOutput("release_instr", IF_ID_instruction, imem[2]);

        // Branch to 0x40 while stalled at PC=0x0C.
        applyStimulus(1, 1, 1, 32'h40);
        checkOutput("br_pc", PC, 32'h40);
        checkOutput("br_bubble", 32'(IF_ID_valid), 32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("br_target_ifpc", IF_ID_PC, 32'h40);
        checkOutput("br_target_valid", 32'(IF_ID_valid), 32'd1);

        // Misaligned branch target faults; later traffic is ignored.
        applyStimulus(1, 0, 1, 32'h42);
        checkOutput("misalign_fault", 32'(fault), 32'd1);
        checkOutput("misalign_fpc", faultPC, 32'h42);
        applyStimulus(1, 0, 1, 32'h10);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("fault_hold_fpc", faultPC, 32'h42);

        // Reset during FAULT.
        applyStimulus(0, 0, 1, 32'h42);
        checkOutput("rst_fault_clear", 32'(fault), 32'd0);

        // Run off the end of memory.
        for (int i = 0; i < 32; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("end_ifpc", IF_ID_PC, 32'h7C);
        checkOutput("end_pc", PC, 32'h80);
        applyStimulus(1, 1, 0, 0);
        checkOutput("end_stall_nofault", 32'(fault), 32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("end_fault", 32'(fault), 32'd1);
        checkOutput("end_fpc", faultPC, 32'h80);
        checkOutput("end_count", fetchCount, 32'd32);

        // Out-of-range aligned target, then reset during a stall.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'h80);
        checkOutput("oor_fpc", faultPC, 32'h80);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("rst_stall_count", fetchCount, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       t = 32'($urandom_range(0, 31)) * 4;
                1:       t = 32'($urandom_range(0, 31)) * 4;
                2:       t = 32'($urandom_range(0, 140));
                default: t = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 8),
                          t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage feeding the 32-word instruction memory and the decode stage. Owns the program counter, presents it to the instruction memory, and captures the returned word into an IF/ID pipeline register with PC and valid bit. Handles downstream stalls, branch redirects with flush, and misaligned or out-of-range fetch faults.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 32, instruction memory depth in words; legal PC range is 0 to IMEM_WORDS*4-4.
- clock  in  1  rising-edge clock; the block's only clock.
- reset  in  1  synchronous, active-low reset; sampled only at the rising edge of `clock`.
- PC  out  32  fetch address driven to the instruction memory, which indexes it as PC/4.
- instruction  in  32  word returned by the instruction memory for the current PC, valid within the same cycle.
- stall  in  1  decode not ready; hold PC and the IF/ID register.
- branchTaken  in  1  redirect request from execute.
- branchTarget  in  32  redirect address, qualified by branchTaken.
- IF_ID_instruction  out  32  captured instruction.
- IF_ID_PC  out  32  PC of the captured instruction.
- IF_ID_valid  out  1  IF/ID register holds a real instruction.
- fault  out  1  sticky fetch fault flag.
- faultPC  out  32  offending address of the first fault.
- fetchCount  out  32  number of instructions accepted into IF/ID, wraps modulo 2^32.

## Operation
- FSM states: RUN and FAULT. Reset enters RUN.
- Reset, with reset==0 at an edge, sets PC=RESET_PC, IF_ID_instruction=0, IF_ID_PC=0, IF_ID_valid=0, fault=0, faultPC=0, fetchCount=0, and state=RUN.
- Priority per edge in RUN: branchTaken, then fault detection, then stall, then normal advance.
- Normal advance (no stall, no branch, PC legal):
  - IF_ID_instruction <= instruction, IF_ID_PC <= PC, IF_ID_valid <= 1.
  - PC <= PC+4 (32-bit add, no carry out).
  - fetchCount <= fetchCount+1.
- Stall (no branch): PC, IF_ID_*, and fetchCount hold unchanged.
- Branch, when branchTaken==1 with an aligned, in-range target:
  - PC <= branchTarget and IF_ID_valid <= 1'b0 (flush/bubble).
  - IF_ID_instruction and IF_ID_PC hold.
  - fetchCount is unchanged.
  - Branch overrides stall.
- Fault conditions:
  - branchTarget[1:0]!=0 or branchTarget >= IMEM_WORDS*4 while branchTaken==1, giving faultPC=branchTarget.
  - Current PC >= IMEM_WORDS*4 when an advance would occur (not stalled), giving faultPC=PC.
- Fault action: fault <= 1, IF_ID_valid <= 0, state <= FAULT. PC and fetchCount are not updated.
- FAULT state: all registers hold; stall and branchTaken are ignored. Only reset exits.
- Sequential PC reaching IMEM_WORDS*4 is not itself a fault; the fault occurs on the next non-stalled edge.

## Timing
- Fetch latency is 1 cycle. The word at PC in cycle n appears on IF_ID_instruction after edge n, with IF_ID_valid=1.
- Redirect penalty is 1 bubble. A branch sampled at edge n fetches the target in cycle n+1, and the target is valid in IF/ID after edge n+1.
- reset low mid-operation: the state at the next edge equals the reset values, regardless of stall, branch, or fault.
- First fetch after reset release: PC=RESET_PC is presented in the first cycle with reset==1. IF_ID_valid is 1 after that cycle's edge if not stalled.
- fault and faultPC update at the detecting edge and remain stable until reset.
- All outputs are registered except that PC is driven directly from the PC register.

## Test plan
- Reset then run 4 cycles with memory words A,B,C,D at 0,4,8,12:
  - IF_ID_PC=0,4,8,12 and instructions A..D.
  - IF_ID_valid=1 from the first edge after reset release.
  - fetchCount=4.
- Stall at PC=8 for 3 cycles, then release:
  - PC stays 8 and IF_ID holds (PC=4, B) for 3 cycles.
  - fetchCount stays 2.
  - After release, IF_ID=(8,C).
- branchTaken with branchTarget=0x40 while PC=0x0C, stall=1 in the same cycle:
  - Next cycle PC=0x40 and IF_ID_valid=0.
  - One cycle later IF_ID_PC=0x40 with IF_ID_valid=1.
- branchTarget=0x42:
  - fault=1, faultPC=0x42, IF_ID_valid=0, state FAULT.
  - Further branches and stalls cause no change.
- Run sequentially to PC=0x7C then one more fetch:
  - IF_ID_PC=0x7C is valid.
  - Next edge gives fault=1, faultPC=0x80, fetchCount=32.
- Assert reset low during FAULT and during a stall:
  - Next edge gives PC=RESET_PC, fault=0, fetchCount=0, IF_ID_valid=0.
